// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_unit_if : imem req/ack bus plus controller/datapath handoff
// Revision: 1.0
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        pc_src;
  logic [31:0] branch_offset;
  logic        stall;
  logic [31:0] instruction;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic [31:0] instr_count;
  logic        fault;

  // fetch unit side
  modport master (
    output imem_req, imem_addr, instruction, op, func, pc, pc_plus4,
           instr_valid, instr_count, fault,
    input  imem_ack, imem_data, pc_src, branch_offset, stall
  );

  // memory / controller / datapath side
  modport slave (
    input  imem_req, imem_addr, instruction, op, func, pc, pc_plus4,
           instr_valid, instr_count, fault,
    output imem_ack, imem_data, pc_src, branch_offset, stall
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_unit : PC holder and one-at-a-time instruction fetch with
//                    retire counter and sticky fetch-timeout fault
// Revision: 1.0
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  wire logic           clk,
  input  wire logic           rst,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic [31:0] r_count;
  logic        r_fault;
  logic [7:0]  r_wait_cnt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_off;
  logic [31:0] w_next_pc;
  logic [7:0]  w_cnt_next;
  logic        w_timeout_hit;
  logic        w_unused_ok;

  assign w_pc_plus4    = r_pc + 32'd4;
  // word offset to byte offset; the top two offset bits fall off
  assign w_branch_off  = {bus.branch_offset[29:0], 2'b00};
  assign w_next_pc     = bus.pc_src ? (w_pc_plus4 + w_branch_off) : w_pc_plus4;
  assign w_cnt_next    = r_wait_cnt + 8'd1;
  assign w_timeout_hit = (TIMEOUT != 8'd0) && (w_cnt_next == TIMEOUT);
  assign w_unused_ok   = &{1'b0, bus.branch_offset[31:30]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= c_reset_pc;
      r_pc       <= c_reset_pc;
      r_instr    <= 32'd0;
      r_valid    <= 1'b0;
      r_count    <= 32'd0;
      r_fault    <= 1'b0;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req      <= 1'b1;
          r_addr     <= r_pc;
          r_wait_cnt <= 8'd0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // an ack on the final allowed cycle takes priority over the fault
          if (bus.imem_ack) begin
            r_instr <= bus.imem_data;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_VALID;
          end else begin
            r_wait_cnt <= w_cnt_next;
            if (w_timeout_hit) begin
              r_fault <= 1'b1;
              r_req   <= 1'b0;
              r_state <= S_FAULT;
            end
          end
        end
        S_VALID: begin
          if (!bus.stall) begin
            r_pc    <= w_next_pc;
            r_count <= r_count + 32'd1;
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_FAULT: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
        default: r_state <= S_FAULT;
      endcase
    end
  end

  // an empty slot must decode as the controller's inert default, never as sll
  assign bus.op          = r_valid ? r_instr[31:26] : 6'b111111;
  assign bus.func        = r_valid ? r_instr[5:0]   : 6'b000000;
  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instruction = r_instr;
  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;
  assign bus.instr_valid = r_valid;
  assign bus.instr_count = r_count;
  assign bus.fault       = r_fault;

endmodule
`default_nettype wire
